// File: rtl/tmds_rx_if.sv
// tmds_rx_if: raw deserialized word in, decoded symbol/lock status out (TMDS_RX_LOSS_CNT_EN adds loss_cnt_o/loss_o)
interface tmds_rx_if;
  logic [9:0] d_i;
  logic       de_o;
  logic       c1_o;
  logic       c0_o;
  logic [7:0] d_o;
  logic       locked_o;
  logic [3:0] slip_o;
`ifdef TMDS_RX_LOSS_CNT_EN
  logic [15:0] loss_cnt_o;
  logic        loss_o;
  modport master(output d_i, input de_o, c1_o, c0_o, d_o, locked_o, slip_o, loss_cnt_o, loss_o);
  modport slave(input d_i, output de_o, c1_o, c0_o, d_o, locked_o, slip_o, loss_cnt_o, loss_o);
`else
  modport master(output d_i, input de_o, c1_o, c0_o, d_o, locked_o, slip_o);
  modport slave(input d_i, output de_o, c1_o, c0_o, d_o, locked_o, slip_o);
`endif
endinterface

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: TMDS symbol aligner, lock tracker and decoder; TMDS_RX_LOSS_CNT_EN adds lock-loss counter/pulse
module tmds_rx_channel #(
  parameter int SEARCH_WIN = 4096,
  parameter int LOCK_RUN   = 16
) (
  input logic      clk_i,
  input logic      rst_n_i,
  tmds_rx_if.slave rx
);
  localparam int WW = $clog2(SEARCH_WIN);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(SEARCH_WIN - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_RUN - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_RUN);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t        state_q, state_n;
  logic [WW-1:0] win_q, win_n;
  logic [RW-1:0] run_q, run_n;
  logic [3:0]    slip_q, slip_n;
  logic [9:0]    d_q, sym_q;
  logic          tok;
  logic [1:0]    tok_c;
  logic [7:0]    dd, dec;
  assign tok   = sym_q inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
  assign tok_c = {sym_q == 10'h154 || sym_q == 10'h2AB, sym_q == 10'h0AB || sym_q == 10'h2AB};
  assign dd    = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
  assign dec[0] = dd[0];
  for (genvar i = 1; i < 8; i++) begin : g_dec
    assign dec[i] = dd[i] ^ dd[i-1] ^ ~sym_q[8];
  end
  // d_q holds the earlier bits, so shifting by slip picks a 10-bit window straddling both words
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      d_q   <= '0;
      sym_q <= '0;
    end else begin
      d_q   <= rx.d_i;
      sym_q <= 10'({rx.d_i, d_q} >> slip_q);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= SEARCH;
      win_q   <= '0;
      run_q   <= '0;
      slip_q  <= '0;
    end else begin
      state_q <= state_n;
      win_q   <= win_n;
      run_q   <= run_n;
      slip_q  <= slip_n;
    end
  end
  // lock wins over a slip advance landing in the same cycle
  always_comb begin
    state_n = state_q;
    win_n   = win_q + 1'b1;
    run_n   = run_q;
    slip_n  = slip_q;
    if (state_q == SEARCH) begin
      run_n = !tok ? '0 : (run_q == RUN_MAX ? run_q : run_q + 1'b1);
      if (tok && run_q == RUN_LAST) begin
        state_n = LOCKED;
        win_n   = '0;
        run_n   = '0;
      end else if (win_q == WIN_LAST) begin
        slip_n = slip_q == 4'd9 ? 4'd0 : slip_q + 4'd1;
        win_n  = '0;
        run_n  = '0;
      end
    end else begin
      win_n = tok ? '0 : win_q + 1'b1;
      if (!tok && win_q == WIN_LAST) begin
        state_n = SEARCH;
        win_n   = '0;
        run_n   = '0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state_q != LOCKED) begin
      rx.de_o <= 1'b0;
      rx.c1_o <= 1'b0;
      rx.c0_o <= 1'b0;
      rx.d_o  <= '0;
    end else begin
      rx.de_o <= !tok;
      rx.d_o  <= tok ? 8'h00 : dec;
      if (tok) {rx.c1_o, rx.c0_o} <= tok_c;
    end
  end
  assign rx.locked_o = state_q == LOCKED;
  assign rx.slip_o   = slip_q;
`ifdef TMDS_RX_LOSS_CNT_EN
  logic        lost, loss_q;
  logic [15:0] loss_cnt_q;
  assign lost = state_q == LOCKED && state_n == SEARCH;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      loss_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      loss_q     <= lost;
      loss_cnt_q <= loss_cnt_q + 16'(lost && ~&loss_cnt_q);
    end
  end
  assign rx.loss_o     = loss_q;
  assign rx.loss_cnt_o = loss_cnt_q;
`endif
endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: directed checks of alignment search, lock, decode, lock loss, slip wrap and reset
module tb_tmds_rx_channel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [9:0] prev = 10'h0;
  tmds_rx_if rx();
  tmds_rx_channel #(.SEARCH_WIN(64), .LOCK_RUN(8)) dut (.clk_i(clk), .rst_n_i(rst_n), .rx(rx.slave));
  always #5 clk = ~clk;
`ifdef TMDS_RX_LOSS_CNT_EN
  int hi = 0;
  int rises = 0;
  logic last = 1'b0;
  always @(negedge clk) begin
    if (rx.loss_o) hi++;
    if (rx.loss_o && !last) rises++;
    last = rx.loss_o;
  end
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic de, input logic c1, input logic c0, input logic [7:0] d);
    chk({tag, ".de"}, 16'(rx.de_o), 16'(de));
    chk({tag, ".c1"}, 16'(rx.c1_o), 16'(c1));
    chk({tag, ".c0"}, 16'(rx.c0_o), 16'(c0));
    chk({tag, ".d"}, 16'(rx.d_o), 16'(d));
  endtask
  // serial stream with each symbol starting at bit 3 of the word
  task automatic send(input logic [9:0] s);
    rx.d_i = {s[6:0], prev[9:7]};
    prev = s;
    tick();
  endtask
  initial begin
    int n;
    rx.d_i = 10'h0;
    tick();
    tick();
    chk_out("rst", 0, 0, 0, 8'h00);
    chk("rst.locked", 16'(rx.locked_o), 16'd0);
    chk("rst.slip", 16'(rx.slip_o), 16'd0);
    rx.d_i = 10'h354;
    rst_n = 1'b1;
    repeat (9) tick();
    chk("lock0.early", 16'(rx.locked_o), 16'd0);
    tick();
    chk("lock0.locked", 16'(rx.locked_o), 16'd1);
    tick();
    chk_out("lock0", 0, 0, 0, 8'h00);
    chk("lock0.slip", 16'(rx.slip_o), 16'd0);
    rst_n = 1'b0;
    prev = 10'h0AB;
    rx.d_i = 10'h159;
    tick();
    rst_n = 1'b1;
    chk("midrst.locked", 16'(rx.locked_o), 16'd0);
    repeat (63) send(10'h0AB);
    chk("srch.slip63", 16'(rx.slip_o), 16'd0);
    send(10'h0AB);
    chk("srch.slip64", 16'(rx.slip_o), 16'd1);
    repeat (64) send(10'h0AB);
    chk("srch.slip128", 16'(rx.slip_o), 16'd2);
    repeat (64) send(10'h0AB);
    chk("srch.slip192", 16'(rx.slip_o), 16'd3);
    repeat (8) send(10'h0AB);
    chk("srch.early", 16'(rx.locked_o), 16'd0);
    send(10'h0AB);
    chk("srch.locked", 16'(rx.locked_o), 16'd1);
    send(10'h0AB);
    chk_out("srch", 0, 0, 1, 8'h00);
    chk("srch.slip", 16'(rx.slip_o), 16'd3);
    send(10'h100);
    send(10'h2FF);
    send(10'h0AB);
    chk_out("d100", 1, 0, 1, 8'h00);
    send(10'h1A5);
    chk_out("d2ff", 1, 0, 1, 8'hFE);
    send(10'h25A);
    chk_out("tokmid", 0, 0, 1, 8'h00);
    send(10'h0AB);
    chk_out("d1a5", 1, 0, 1, 8'hEF);
    send(10'h0AB);
    chk_out("d25a", 1, 0, 1, 8'h11);
    repeat (6) send(10'h0AB);
    repeat (65) send(10'h100);
    chk("loss.still", 16'(rx.locked_o), 16'd1);
    chk("loss.de", 16'(rx.de_o), 16'd1);
    send(10'h100);
    chk("loss.locked", 16'(rx.locked_o), 16'd0);
    send(10'h100);
    chk_out("loss", 0, 0, 0, 8'h00);
    chk("loss.slip", 16'(rx.slip_o), 16'd3);
    repeat (9) send(10'h0AB);
    chk("relock.early", 16'(rx.locked_o), 16'd0);
    send(10'h0AB);
    chk("relock.locked", 16'(rx.locked_o), 16'd1);
    send(10'h0AB);
    chk_out("relock", 0, 0, 1, 8'h00);
    rx.d_i = 10'h100;
    n = 0;
    while (rx.slip_o != 4'd9 && n < 2000) begin
      tick();
      n++;
    end
    chk("wrap.reach9", 16'(rx.slip_o), 16'd9);
    n = 0;
    while (rx.slip_o == 4'd9 && n < 100) begin
      tick();
      n++;
    end
    chk("wrap.slip", 16'(rx.slip_o), 16'd0);
    chk("wrap.cycles", 16'(n), 16'd64);
    n = 0;
    while (rx.slip_o != 4'd5 && n < 400) begin
      tick();
      n++;
    end
    chk("s5.reach", 16'(rx.slip_o), 16'd5);
    rx.d_i = 10'h175;
    repeat (9) tick();
    chk("s5.early", 16'(rx.locked_o), 16'd0);
    tick();
    chk("s5.locked", 16'(rx.locked_o), 16'd1);
    tick();
    chk_out("s5", 0, 1, 1, 8'h00);
    chk("s5.slip", 16'(rx.slip_o), 16'd5);
`ifdef TMDS_RX_LOSS_CNT_EN
    rx.d_i = 10'h100;
    n = 0;
    while (rx.locked_o && n < 200) begin
      tick();
      n++;
    end
    chk("loss3.locked", 16'(rx.locked_o), 16'd0);
    tick();
    chk("loss3.cnt", rx.loss_cnt_o, 16'd3);
    chk("loss3.rises", 16'(rises), 16'd3);
    chk("loss3.hi", 16'(hi), 16'd3);
    rx.d_i = 10'h175;
    n = 0;
    while (!rx.locked_o && n < 100) begin
      tick();
      n++;
    end
    chk("loss3.relock", 16'(rx.locked_o), 16'd1);
    chk("loss3.slip", 16'(rx.slip_o), 16'd5);
    tick();
`endif
    rst_n = 1'b0;
    tick();
    chk_out("rst2", 0, 0, 0, 8'h00);
    chk("rst2.locked", 16'(rx.locked_o), 16'd0);
    chk("rst2.slip", 16'(rx.slip_o), 16'd0);
`ifdef TMDS_RX_LOSS_CNT_EN
    chk("rst2.cnt", rx.loss_cnt_o, 16'd0);
`endif
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
